primitive_device_ctrl: RTL
==========================

// Module: primitive_device_ctrl
// PURPOSE
//  Run/step sequencer for the single-cycle primitive device: generates its enable and reset.
//  Turns a raw step push-button and a run switch into en_o pulses (single-step or divided free-run).
//  Halts on the device's done flag or on an instruction limit, and counts executed instructions.
//  Sits between board I/O (buttons/switches) and the device; en_o->en_i, dev_rst_o->rst_i, done_i<-done_o.
// PARAMETERS
//  DEBOUNCE_CYCLES 16  consecutive stable synchronized samples before the debounced step level changes (>=1)
//  RUN_DIV         4   RUN mode issues one en_o pulse every RUN_DIV cycles (>=1; 1 = every cycle)
//  CNT_W           16  width of instruction counter
//  MAX_INSTR       0   halt after this many enables; 0 = unlimited
// PORTS
//  clk_i        in   1      system clock
//  rst_ni       in   1      asynchronous active-low reset
//  step_btn_i   in   1      raw step button, asynchronous, bouncing
//  run_sw_i     in   1      raw run switch, asynchronous, level
//  clear_i      in   1      raw restart request, asynchronous, level
//  done_i       in   1      device done flag, valid only while en_o=1
//  en_o         out  1      device enable, one-cycle pulses
//  dev_rst_o    out  1      active-high device reset
//  halted_o     out  1      1 while in HALT
//  instr_cnt_o  out  CNT_W  enables issued since last clear, saturating
//  state_o      out  3      FSM state: CLR=0 IDLE=1 STEP=2 RUN=3 HALT=4
// BEHAVIOUR
//  Reset (rst_ni=0): state=CLR, clr_cnt=0, en_o=0, dev_rst_o=1, halted_o=0, instr_cnt_o=0, sync/debounce flops=0.
//  Inputs: step_btn_i, run_sw_i, clear_i each pass through a 2-flop synchronizer (2-edge latency).
//  Debounce (step only): cnt counts cycles with sync!=deb; reset to 0 when equal;
//   at cnt==DEBOUNCE_CYCLES-1 with sync!=deb: deb<=sync, cnt<=0. step_pulse = deb & ~deb_d (one cycle).
//  All outputs are decoded from registered state only; there is no combinational input->output path.
//  en_o = (state==STEP) | (state==RUN & div==RUN_DIV-1). dev_rst_o = (state==CLR). halted_o = (state==HALT).
//  Priority each cycle: clear_sync > done/limit > run_sw change > step_pulse.
//  CLR: dev_rst_o=1 for exactly 2 cycles (clr_cnt 0,1), instr_cnt<=0, div<=0 -> IDLE.
//   If clear_sync stays 1, CLR is held (clr_cnt holds at 1); exit 1 cycle after clear_sync falls.
//  IDLE: run_sync=1 -> RUN (div<=0); else step_pulse -> STEP; else stay.
//  STEP: en_o=1 for one cycle; instr_cnt++.
//   Next state: HALT if done_i, or if MAX_INSTR!=0 and cnt+1==MAX_INSTR; otherwise IDLE.
//  RUN: div counts 0..RUN_DIV-1 and wraps. On the en_o cycle: instr_cnt++; done_i or limit -> HALT.
//   run_sync=0 -> IDLE and div<=0. If that coincides with an en_o cycle, the instruction still counts
//   and done/limit still wins, going to HALT.
//  HALT: en_o=0; ignores step and run; exits only via clear -> CLR.
//  step_pulse outside IDLE is dropped, never queued. A single button press yields at most one step.
//  instr_cnt saturates at 2^CNT_W-1 (no wrap). MAX_INSTR>2^CNT_W-1 behaves as unlimited.
//  Step latency: en_o is high on edge 2+DEBOUNCE_CYCLES+2 after the first edge sampling a clean button=1.
//  rst_ni asserted mid-RUN: en_o drops immediately and dev_rst_o asserts immediately (asynchronous).
// TESTING  (DEBOUNCE_CYCLES=4, RUN_DIV=3, CNT_W=8, MAX_INSTR=0 unless noted)
//  Reset release, all inputs 0 -> dev_rst_o=1 for 2 cycles, then state_o=1 with en_o=0 and instr_cnt_o=0.
//  Clean button press held 20 cycles in IDLE -> en_o=1 for exactly one cycle, 8 edges after the press;
//   instr_cnt_o=1.
//  Button bounces 1,0,1,0 (1-cycle glitches) then stays 1 -> exactly one en_o pulse; glitches <4 cycles
//   are ignored.
//  run_sw_i=1 for 30 cycles, done_i=0 -> en_o pulses every 3rd cycle; instr_cnt_o increments per pulse;
//   run_sw_i=0 -> IDLE.
//  RUN with done_i=1 on the 4th en_o -> HALT, halted_o=1, instr_cnt_o=4; step/run ignored;
//   clear_i pulse -> CLR 2 cycles -> IDLE, cnt=0.
//  MAX_INSTR=3, RUN_DIV=1 -> exactly 3 consecutive en_o cycles, then HALT.
//   Also: step pressed during RUN -> no extra pulse.

Source files
------------

// File: rtl/primitive_device_ctrl.sv
// Run/step sequencer for the single-cycle primitive device.
// Turns a bouncing step button and a run switch into one-cycle device enables, holds the
// device in reset while clearing, halts on done or on an instruction limit and counts enables.
module primitive_device_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned RUN_DIV         = 4,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned MAX_INSTR       = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             step_btn_i,
  input  logic             run_sw_i,
  input  logic             clear_i,
  input  logic             done_i,
  output logic             en_o,
  output logic             dev_rst_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] instr_cnt_o,
  output logic [2:0]       state_o
);

  localparam int unsigned DbW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned DivW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DivW-1:0] DivLast = DivW'(RUN_DIV - 1);
  // A limit the saturating counter can never reach is treated as no limit at all.
  localparam bit LimitEn = (MAX_INSTR != 0) && (64'(MAX_INSTR) < (64'd1 << CNT_W));
  localparam logic [CNT_W-1:0] LimitLast = CNT_W'(MAX_INSTR - 1);

  typedef enum logic [2:0] {
    StClr  = 3'd0,
    StIdle = 3'd1,
    StStep = 3'd2,
    StRun  = 3'd3,
    StHalt = 3'd4
  } state_e;

  // Synchronizer bit order: {clear, run, step}
  logic [2:0] sync1_q, sync2_q;
  logic       step_sync, run_sync, clear_sync;

  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           deb_q, deb_d;
  logic           deb_prev_q;
  logic           step_pulse_q;

  state_e          state_q, state_d;
  logic            clr_cnt_q, clr_cnt_d;
  logic [DivW-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             en_cycle;
  logic             limit_hit;
  logic [CNT_W-1:0] cnt_inc;

  assign step_sync  = sync2_q[0];
  assign run_sync   = sync2_q[1];
  assign clear_sync = sync2_q[2];

  // Two-flop synchronizers for the asynchronous board inputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {clear_i, run_sw_i, step_btn_i};
      sync2_q <= sync1_q;
    end
  end

  // Debounce: the level only follows the input after DEBOUNCE_CYCLES disagreeing samples
  always_comb begin
    db_cnt_d = '0;
    deb_d    = deb_q;
    if (step_sync != deb_q) begin
      if (db_cnt_q == DbLast) begin
        deb_d = step_sync;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Debounce state and registered rising-edge pulse of the clean step level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_cnt_q     <= '0;
      deb_q        <= 1'b0;
      deb_prev_q   <= 1'b0;
      step_pulse_q <= 1'b0;
    end else begin
      db_cnt_q     <= db_cnt_d;
      deb_q        <= deb_d;
      deb_prev_q   <= deb_q;
      step_pulse_q <= deb_q & ~deb_prev_q;
    end
  end

  assign en_cycle  = (state_q == StRun) && (div_q == DivLast);
  assign limit_hit = LimitEn && (cnt_q == LimitLast);
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // Next-state logic; clear outranks done/limit, which outranks run, which outranks step
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    if (clear_sync && (state_q != StClr)) begin
      state_d   = StClr;
      clr_cnt_d = 1'b0;
    end else begin
      case (state_q)
        StClr: begin
          cnt_d = '0;
          div_d = '0;
          if (!clr_cnt_q) begin
            clr_cnt_d = 1'b1;
          end else if (!clear_sync) begin
            state_d = StIdle;
          end
        end
        StIdle: begin
          if (run_sync) begin
            state_d = StRun;
            div_d   = '0;
          end else if (step_pulse_q) begin
            state_d = StStep;
          end
        end
        StStep: begin
          cnt_d   = cnt_inc;
          state_d = (done_i || limit_hit) ? StHalt : StIdle;
        end
        StRun: begin
          if (en_cycle) begin
            cnt_d = cnt_inc;
            div_d = '0;
          end else begin
            div_d = div_q + 1'b1;
          end
          if (en_cycle && (done_i || limit_hit)) begin
            state_d = StHalt;
          end else if (!run_sync) begin
            state_d = StIdle;
            div_d   = '0;
          end
        end
        StHalt: begin
          state_d = StHalt;
        end
        default: begin
          state_d = StClr;
        end
      endcase
    end
  end

  // Sequencer state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StClr;
      clr_cnt_q <= 1'b0;
      div_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
    end
  end

  assign en_o        = (state_q == StStep) | en_cycle;
  assign dev_rst_o   = (state_q == StClr);
  assign halted_o    = (state_q == StHalt);
  assign instr_cnt_o = cnt_q;
  assign state_o     = state_q;

endmodule
